// File: rtl/module_data_arbiter.sv
// Round-robin, burst-limited arbiter merging per-module first-word-fall-through FIFOs into one stream.
// Disabled modules are drained and dropped; per-module forwarded-word counters saturate.
module module_data_arbiter #(
    parameter int NMODULES  = 4,
    parameter int LENGTH    = 128,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 32,
    localparam int SRC_W    = (NMODULES > 1) ? $clog2(NMODULES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NMODULES-1:0]          en,
    input  logic [NMODULES-1:0]          in_valid,
    output logic [NMODULES-1:0]          in_ready,
    input  logic [NMODULES*LENGTH-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LENGTH-1:0]            out_data,
    output logic [SRC_W-1:0]             out_src,
    input  logic                         cnt_clr,
    output logic [NMODULES*CNT_W-1:0]    fwd_count,
    output logic                         drop_pulse
);

    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
    localparam logic [SRC_W-1:0]  LAST_SRC  = SRC_W'(NMODULES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {ARB, XFER} state_t;

    state_t              state_reg;
    logic [SRC_W-1:0]    ptr_reg;
    logic [SRC_W-1:0]    grant_reg;
    logic [BEAT_W-1:0]   beat_reg;
    logic                out_valid_reg;
    logic [LENGTH-1:0]   out_data_reg;
    logic [SRC_W-1:0]    out_src_reg;
    logic                drop_pulse_reg;
    logic [CNT_W-1:0]    cnt_reg [NMODULES];

    logic [LENGTH-1:0]   word [NMODULES];
    logic [NMODULES-1:0] req;
    logic [SRC_W-1:0]    grant_next;
    logic [SRC_W-1:0]    cand;
    logic                have_req;
    logic                space;
    logic                fire;
    logic                burst_end;

    assign space     = ~out_valid_reg | out_ready;
    assign req       = in_valid & en;
    assign fire      = (state_reg == XFER) & in_valid[grant_reg] & en[grant_reg] & space;
    assign burst_end = ~in_valid[grant_reg] | ~en[grant_reg] | (fire & (beat_reg == LAST_BEAT));

    generate
        for (genvar gi = 0; gi < NMODULES; gi++) begin : g_mod
            assign word[gi] = in_data[gi*LENGTH +: LENGTH];
            // Disabled modules are always read (drained); the enabled path needs the grant.
            assign in_ready[gi] = ~en[gi] |
                                  ((state_reg == XFER) & (grant_reg == SRC_W'(gi)) & space);
            assign fwd_count[gi*CNT_W +: CNT_W] = cnt_reg[gi];

            always_ff @(posedge clk) begin
                if (!rst || cnt_clr) begin
                    cnt_reg[gi] <= '0;
                end else if (fire && (grant_reg == SRC_W'(gi)) && (cnt_reg[gi] != CNT_MAX)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    // First requester at or after ptr, wrapping around.
    always_comb begin
        grant_next = ptr_reg;
        have_req   = 1'b0;
        cand       = ptr_reg;
        for (int k = 0; k < NMODULES; k++) begin
            if (req[cand] && !have_req) begin
                grant_next = cand;
                have_req   = 1'b1;
            end
            cand = (cand == LAST_SRC) ? '0 : cand + SRC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ARB;
            ptr_reg   <= '0;
            grant_reg <= '0;
            beat_reg  <= '0;
        end else begin
            case (state_reg)
                ARB: begin
                    if (have_req) begin
                        grant_reg <= grant_next;
                        beat_reg  <= '0;
                        state_reg <= XFER;
                    end
                end
                XFER: begin
                    if (burst_end) begin
                        state_reg <= ARB;
                        ptr_reg   <= (grant_reg == LAST_SRC) ? '0 : grant_reg + SRC_W'(1);
                    end else if (fire) begin
                        beat_reg <= beat_reg + BEAT_W'(1);
                    end
                end
                default: state_reg <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_src_reg    <= '0;
            drop_pulse_reg <= 1'b0;
        end else begin
            drop_pulse_reg <= |(in_valid & ~en);
            if (fire) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= word[grant_reg];
                out_src_reg   <= grant_reg;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_src    = out_src_reg;
    assign drop_pulse = drop_pulse_reg;

endmodule

// File: tb/tb_module_data_arbiter.sv
// Bench for module_data_arbiter: FIFO models feed the arbiter, accepted words go to a scoreboard.
// Table vectors cover enable/fill mixes; hand sequences cover ordering, stalls, mid-burst disable, counters.
module tb_module_data_arbiter;

    localparam int N  = 4;
    localparam int L  = 128;
    localparam int MB = 4;
    localparam int CW = 4;
    localparam int D  = 64;
    localparam int CMAXI = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   en;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*L-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [L-1:0]   out_data;
    logic [1:0]     out_src;
    logic           cnt_clr;
    logic [N*CW-1:0] fwd_count;
    logic           drop_pulse;

    always #5 clk = ~clk;

    module_data_arbiter #(
        .NMODULES(N), .LENGTH(L), .MAX_BURST(MB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .cnt_clr(cnt_clr),
        .fwd_count(fwd_count), .drop_pulse(drop_pulse)
    );

    typedef struct packed {
        logic [1:0]   src;
        logic [L-1:0] data;
    } exp_t;

    typedef struct packed {
        logic [3:0]      en;
        logic [3:0][7:0] n;
        logic            bp;
        logic [3:0][7:0] cnt;
        logic [7:0]      drops;
    } vec_t;

    logic [L-1:0] fmem [N][D];
    int           rd_p [N];
    int           wr_p [N];
    int           cnt_m [N];
    exp_t         exp_q [$];
    int           order_q [$];
    vec_t         vecs [5];

    int  npass = 0, nchecks = 0;
    int  nout = 0, ndrop = 0, tick_no = 0, first_out = -1, last_out = -1;
    bit  armed = 0;
    bit  drop_exp = 0;

    task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
        nchecks++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(logic [3:0] e, int a0, int a1, int a2, int a3, bit b,
                                int c0, int c1, int c2, int c3, int d);
        vec_t v;
        v.en = e; v.bp = b; v.drops = 8'(d);
        v.n[0] = 8'(a0); v.n[1] = 8'(a1); v.n[2] = 8'(a2); v.n[3] = 8'(a3);
        v.cnt[0] = 8'(c0); v.cnt[1] = 8'(c1); v.cnt[2] = 8'(c2); v.cnt[3] = 8'(c3);
        return v;
    endfunction

    function automatic bit idle();
        bit r = (exp_q.size() == 0) && (out_valid == 1'b0);
        for (int i = 0; i < N; i++) if (wr_p[i] != rd_p[i]) r = 0;
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i] = (wr_p[i] != rd_p[i]);
            in_data[i*L +: L] = in_valid[i] ? fmem[i][rd_p[i] % D] : '0;
        end
    endtask

    task automatic load(input int m, input int n);
        logic [L-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            w[127:120] = 8'(m);
            w[119:104] = 16'(wr_p[m]);
            fmem[m][wr_p[m] % D] = w;
            wr_p[m]++;
        end
        drive();
    endtask

    // One clock: sample just after the falling edge, update models after the rising edge.
    task automatic tick();
        logic [N-1:0] fire_s, en_s;
        logic rst_s, clr_s;
        exp_t e;
        #1;
        fire_s = in_valid & in_ready;
        en_s   = en;
        rst_s  = rst;
        clr_s  = cnt_clr;
        if (out_valid === 1'b1 && out_ready) begin
            nout++;
            if (first_out < 0) first_out = tick_no;
            last_out = tick_no;
            if (exp_q.size() == 0) begin
                nchecks++;
                $display("FAIL extra_word: got src %0d data %0h, required no word", out_src, out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_src", L'(out_src), L'(e.src));
                chk("out_data", out_data, e.data);
            end
            if (order_q.size() > 0) chk("rr_order", L'(out_src), L'(order_q.pop_front()));
        end
        if (armed) begin
            chk("drop_pulse", L'(drop_pulse), L'(drop_exp));
            if (drop_pulse) ndrop++;
        end
        drop_exp = rst_s & (|(in_valid & ~en));
        @(posedge clk);
        #1;
        tick_no++;
        if (!rst_s || clr_s) for (int i = 0; i < N; i++) cnt_m[i] = 0;
        for (int i = 0; i < N; i++) begin
            if (fire_s[i]) begin
                e.src  = 2'(i);
                e.data = fmem[i][rd_p[i] % D];
                rd_p[i]++;
                if (rst_s && en_s[i]) begin
                    exp_q.push_back(e);
                    if (!clr_s && cnt_m[i] < CMAXI) cnt_m[i]++;
                end
            end
        end
        if (!rst_s) begin
            exp_q.delete();
            armed = 1;
        end
        drive();
        @(negedge clk);
    endtask

    task automatic run_idle(input bit bp);
        int n = 0;
        while (!idle() && n < 400) begin
            if (bp) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        nchecks++;
        if (idle()) npass++;
        else $display("FAIL drain_timeout: got %0d words still pending, required 0", exp_q.size());
        tick();
        tick();
    endtask

    task automatic wait_pops(input int m, input int k);
        int s = rd_p[m];
        int n = 0;
        while (rd_p[m] - s < k && n < 50) begin
            tick();
            n++;
        end
        nchecks++;
        if (rd_p[m] - s >= k) npass++;
        else $display("FAIL wait_pops: got %0d reads from module %0d, required %0d", rd_p[m] - s, m, k);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic chk_model_cnts(input string nm);
        for (int i = 0; i < N; i++) chk(nm, L'(fwd_count[i*CW +: CW]), L'(cnt_m[i]));
    endtask

    initial begin
        vecs[0] = mk(4'b1011, 3, 2, 6, 1, 0, 3, 2, 0, 1, 6);
        vecs[1] = mk(4'b0101, 5, 4, 3, 2, 1, 5, 0, 3, 0, 4);
        vecs[2] = mk(4'b1110, 7, 1, 0, 9, 1, 0, 1, 0, 9, 7);
        vecs[3] = mk(4'b0000, 2, 5, 1, 3, 0, 0, 0, 0, 0, 5);
        vecs[4] = mk(4'b1111, 9, 0, 5, 2, 1, 9, 0, 5, 2, 0);

        for (int i = 0; i < N; i++) begin rd_p[i] = 0; wr_p[i] = 0; cnt_m[i] = 0; end
        rst = 1'b0; en = 4'b1111; out_ready = 1'b1; cnt_clr = 1'b0;
        drive();
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_out_valid", L'(out_valid), L'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_src", L'(out_src), L'(0));
        chk("rst_in_ready", L'(in_ready), L'(0));
        chk("rst_drop", L'(drop_pulse), L'(0));
        chk("rst_fwd_count", L'(fwd_count), L'(0));

        // All four full: runs of MB words rotating 0..3 with one bubble per grant.
        for (int r = 0; r < 2; r++)
            for (int m = 0; m < N; m++)
                for (int k = 0; k < MB; k++) order_q.push_back(m);
        for (int m = 0; m < N; m++) begin order_q.push_back(m); order_q.push_back(m); end
        first_out = -1;
        for (int m = 0; m < N; m++) load(m, 10);
        run_idle(0);
        chk("t1_span", L'(last_out - first_out), L'(53));
        chk("t1_order_left", L'(order_q.size()), L'(0));
        for (int i = 0; i < N; i++) chk("t1_cnt", L'(fwd_count[i*CW +: CW]), L'(10));

        // Pointer advance and wrap.
        do_reset();
        order_q = '{2, 2, 2};
        load(2, 3);
        run_idle(0);
        order_q = '{3, 3, 1, 1};
        load(1, 2); load(3, 2);
        run_idle(0);
        order_q = '{0, 0, 1, 1};
        load(0, 2); load(1, 2);
        run_idle(0);
        chk("t2_order_left", L'(order_q.size()), L'(0));

        for (int vi = 0; vi < 5; vi++) begin
            en = vecs[vi].en;
            cnt_clr = 1'b1;
            tick();
            cnt_clr = 1'b0;
            ndrop = 0;
            for (int m = 0; m < N; m++) load(m, int'(vecs[vi].n[m]));
            run_idle(vecs[vi].bp);
            for (int m = 0; m < N; m++)
                chk($sformatf("vec%0d_cnt%0d", vi, m), L'(fwd_count[m*CW +: CW]), L'(vecs[vi].cnt[m]));
            chk($sformatf("vec%0d_drops", vi), L'(ndrop), L'(vecs[vi].drops));
        end
        en = 4'b1111;

        // Backpressure mid-burst must hold the word and the grant.
        do_reset();
        order_q = '{1, 1, 1, 1, 2, 2};
        load(1, 4); load(2, 2);
        wait_pops(1, 2);
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("stall_valid", L'(out_valid), L'(1));
            chk("stall_in_ready1", L'(in_ready[1]), L'(0));
            if (exp_q.size() > 0) chk("stall_hold", out_data, exp_q[0].data);
            tick();
        end
        out_ready = 1'b1;
        run_idle(0);
        chk("t3_order_left", L'(order_q.size()), L'(0));
        chk("t3_cnt1", L'(fwd_count[1*CW +: CW]), L'(4));

        // Disable the granted module after its first word.
        do_reset();
        order_q = '{0, 1, 1};
        load(0, 4); load(1, 2);
        wait_pops(0, 1);
        en = 4'b1110;
        ndrop = 0;
        run_idle(0);
        chk("t5_order_left", L'(order_q.size()), L'(0));
        chk("t5_cnt0", L'(fwd_count[0*CW +: CW]), L'(1));
        chk("t5_cnt1", L'(fwd_count[1*CW +: CW]), L'(2));
        chk("t5_drops", L'(ndrop), L'(3));
        en = 4'b1111;

        // Counter saturation, clear-vs-increment, reset mid-transfer.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        load(3, CMAXI + 2);
        run_idle(1);
        chk("t6_sat", L'(fwd_count[3*CW +: CW]), L'(CMAXI));
        load(3, 6);
        wait_pops(3, 2);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        #1;
        chk("t6_clr_prio", L'(fwd_count[3*CW +: CW]), L'(0));
        chk("t6_valid_before_rst", L'(out_valid), L'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", L'(out_valid), L'(0));
        chk("t6_rst_in_ready", L'(in_ready), L'(0));
        chk("t6_rst_cnt", L'(fwd_count), L'(0));
        run_idle(0);
        chk("t6_after_rst_cnt3", L'(fwd_count[3*CW +: CW]), L'(2));
        chk_model_cnts("final_cnt_model");

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
